// File: rtl/block_averaging_stream.sv
// rtl/block_averaging_stream.sv - streaming FACTOR x FACTOR block-average downscaler
module block_averaging_stream #(
  parameter int DATA_W = 8,
  parameter int F_LOG2 = 1,
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ROUND  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam int SUM_W = DATA_W + 2 * F_LOG2;
  localparam int NBLK  = IMG_W >> F_LOG2;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int K_W   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [SUM_W-1:0] ONE  = 1;
  localparam logic [SUM_W-1:0] BIAS = (ROUND != 0) ? (ONE << (2 * F_LOG2 - 1)) : '0;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [SUM_W-1:0]   h_sum_q, h_sum_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [SUM_W-1:0]   lbuf_q [NBLK];

  logic               group_end, first_row, last_row, lbuf_we;
  logic [F_LOG2-1:0]  blk_row;
  logic [K_W-1:0]     k;
  logic [SUM_W-1:0]   lbuf_rd, acc, acc_b;
  logic [DATA_W-1:0]  avg;

  // Column/row position decode and the block sum for the pixel being offered
  always_comb begin
    blk_row   = row_q[F_LOG2-1:0];
    group_end = &col_q[F_LOG2-1:0];
    first_row = (blk_row == '0);
    last_row  = &blk_row;
    k         = K_W'(col_q >> F_LOG2);
    lbuf_rd   = first_row ? '0 : lbuf_q[k];
    acc       = lbuf_rd + h_sum_q + SUM_W'(in_data);
    acc_b     = acc + BIAS;
    avg       = DATA_W'(acc_b >> (2 * F_LOG2));
  end

  // Next-state, handshake and output-register update
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    h_sum_d     = h_sum_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    lbuf_we     = 1'b0;
    in_ready    = 1'b0;
    done        = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          col_d   = '0;
          row_d   = '0;
          h_sum_d = '0;
        end
      end
      S_ACCUM: begin
        in_ready = !out_valid_q || out_ready;
        if (in_valid && in_ready) begin
          h_sum_d = group_end ? '0 : h_sum_q + SUM_W'(in_data);
          if (group_end) begin
            if (last_row) begin
              out_valid_d = 1'b1;
              out_data_d  = avg;
            end else begin
              lbuf_we = 1'b1;
            end
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) state_d = S_DRAIN;
            else row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || out_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      h_sum_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      h_sum_q     <= h_sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Partial-sum line buffer, one entry per output column
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBLK; i++) lbuf_q[i] <= '0;
    end else if (lbuf_we) begin
      lbuf_q[k] <= acc;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_block_averaging_stream.sv
// tb/tb_block_averaging_stream.sv - scoreboard bench for block_averaging_stream
module tb_block_averaging_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, a_start, a_in_valid, a_out_ready;
  logic [7:0] a_in_data;
  logic       a_in_ready, a_out_valid, a_busy, a_done;
  logic [7:0] a_out_data;
  logic       r_in_ready, r_out_valid, r_busy, r_done;
  logic [7:0] r_out_data;
  logic       b_start, b_in_valid, b_out_ready;
  logic [7:0] b_in_data;
  logic       b_in_ready, b_out_valid, b_busy, b_done;
  logic [7:0] b_out_data;

  block_averaging_stream #(.DATA_W(8), .F_LOG2(1), .IMG_W(4), .IMG_H(2), .ROUND(0)) u_trunc (
    .clk(clk), .reset(reset), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .busy(a_busy), .done(a_done));

  block_averaging_stream #(.DATA_W(8), .F_LOG2(1), .IMG_W(4), .IMG_H(2), .ROUND(1)) u_round (
    .clk(clk), .reset(reset), .start(a_start), .in_valid(a_in_valid), .in_ready(r_in_ready),
    .in_data(a_in_data), .out_valid(r_out_valid), .out_ready(a_out_ready), .out_data(r_out_data),
    .busy(r_busy), .done(r_done));

  block_averaging_stream #(.DATA_W(8), .F_LOG2(3), .IMG_W(16), .IMG_H(8), .ROUND(1)) u_big (
    .clk(clk), .reset(reset), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy), .done(b_done));

  int n_vec = 0;
  int n_fail = 0;
  int q_t[$];
  int q_r[$];
  int q_b[$];
  int done_t = 0, done_r = 0, done_b = 0;
  int px[8];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every output handshake, count done pulses
  always @(negedge clk) begin
    if (!reset) begin
      if (a_done) done_t++;
      if (r_done) done_r++;
      if (b_done) done_b++;
      if (a_out_valid && a_out_ready) begin
        if (q_t.size() == 0) check("trunc unexpected output", a_out_data, -1);
        else check("trunc out_data", a_out_data, q_t.pop_front());
      end
      if (r_out_valid && a_out_ready) begin
        if (q_r.size() == 0) check("round unexpected output", r_out_data, -1);
        else check("round out_data", r_out_data, q_r.pop_front());
      end
      if (b_out_valid && b_out_ready) begin
        if (q_b.size() == 0) check("f8 unexpected output", b_out_data, -1);
        else check("f8 out_data", b_out_data, q_b.pop_front());
      end
    end
  end

  task automatic send_a(input int d);
    int n;
    a_in_data = 8'(d);
    a_in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!a_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("trunc in_ready timeout", a_in_ready, 1);
    @(posedge clk);
    #1 a_in_valid = 1'b0;
  endtask

  task automatic send_b(input int d);
    int n;
    b_in_data = 8'(d);
    b_in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("f8 in_ready timeout", b_in_ready, 1);
    @(posedge clk);
    #1 b_in_valid = 1'b0;
  endtask

  task automatic pulse_a_start();
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
  endtask

  task automatic wait_idle_a(input string name);
    int n;
    n = 0;
    while ((a_busy || r_busy) && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    check(name, a_busy, 0);
  endtask

  // Full 4x2 frame from px[]; start_at >= 0 pulses start again before that pixel
  task automatic run_frame(input string name, input int t0, input int t1, input int r0,
                           input int r1, input int start_at);
    q_t.push_back(t0); q_t.push_back(t1);
    q_r.push_back(r0); q_r.push_back(r1);
    pulse_a_start();
    for (int i = 0; i < 8; i++) begin
      if (i == start_at) pulse_a_start();
      send_a(px[i]);
    end
    wait_idle_a(name);
  endtask

  task automatic run_big(input int mode, input int e0, input int e1);
    int n;
    q_b.push_back(e0); q_b.push_back(e1);
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++)
        send_b(mode != 0 ? c : 255);
    n = 0;
    while (b_busy && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    check("f8 frame end", b_busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " trunc in_ready"}, a_in_ready, 0);
    check({tag, " trunc out_valid"}, a_out_valid, 0);
    check({tag, " trunc out_data"}, a_out_data, 0);
    check({tag, " trunc busy"}, a_busy, 0);
    check({tag, " trunc done"}, a_done, 0);
    check({tag, " round out_data"}, r_out_data, 0);
    check({tag, " f8 out_valid"}, b_out_valid, 0);
    check({tag, " f8 busy"}, b_busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    a_start = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // T1: 25, 45 exact under both rounding modes
    px = '{0, 10, 20, 30, 40, 50, 60, 70};
    run_frame("t1 frame end", 25, 45, 25, 45, -1);

    // T2: sums 7 and 22 -> truncate 1,5 ; round 2,6
    px = '{1, 2, 5, 6, 2, 2, 5, 6};
    run_frame("t2 frame end", 1, 5, 2, 6, -1);

    // T4: stall first result (sum 1019 -> 254 / 255) for 5 cycles
    px = '{255, 255, 3, 9, 255, 254, 0, 1};
    q_t.push_back(254); q_t.push_back(3);
    q_r.push_back(255); q_r.push_back(3);
    a_out_ready = 1'b0;
    pulse_a_start();
    for (int i = 0; i < 6; i++) send_a(px[i]);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("t4 stall out_valid", a_out_valid, 1);
      check("t4 stall trunc out_data", a_out_data, 254);
      check("t4 stall round out_data", r_out_data, 255);
      check("t4 stall in_ready", a_in_ready, 0);
    end
    @(posedge clk);
    #1 a_out_ready = 1'b1;
    send_a(px[6]);
    send_a(px[7]);
    wait_idle_a("t4 frame end");

    // T5: reset after 3 pixels, then a clean frame (sums 33, 65 -> 8, 16)
    pulse_a_start();
    for (int i = 0; i < 3; i++) send_a(7 * i + 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5");
    @(posedge clk);
    #1 reset = 1'b0;
    px = '{8, 8, 16, 16, 8, 9, 16, 17};
    run_frame("t5 frame end", 8, 16, 8, 16, -1);

    // T6: start mid-frame ignored (sums 26, 34 -> 6,8 ; 7,9)
    px = '{4, 5, 6, 7, 8, 9, 10, 11};
    run_frame("t6 frame end", 6, 8, 7, 9, 2);

    // T3: 8x downscale, all 255 then a column ramp (224, 736 -> 4, 12 rounded)
    run_big(0, 255, 255);
    run_big(1, 4, 12);

    repeat (3) @(posedge clk);
    check("trunc done count", done_t, 5);
    check("round done count", done_r, 5);
    check("f8 done count", done_b, 2);
    check("trunc leftover expected", q_t.size(), 0);
    check("round leftover expected", q_r.size(), 0);
    check("f8 leftover expected", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
